// File: rtl/codec_config_sequencer.sv
`timescale 1ns/1ps
// codec_config_sequencer
// Boot-time programmer for the WM8731 audio CODEC. Walks a fixed 11-entry
// register table and hands each 24-bit write to an external I2C byte engine
// through a req/done handshake. NACKed writes are resent after a short gap,
// and each entry has a bounded number of resends. The outcome is reported
// as a sticky done or error flag.
module codec_config_sequencer #(
    parameter logic [7:0] DEV_ADDR      = 8'h34,
    parameter int         SETTLE_CYCLES = 50000,
    parameter int         RETRY_GAP     = 1000,
    parameter int         MAX_RETRIES   = 3
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        start,
    output logic        i2c_req,
    output logic [23:0] i2c_data,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  entry_idx
);

    // One counter serves both the post-reset settle delay and the NACK gap,
    // so it is sized for the longer of the two.
    localparam int CNT_MAX = (SETTLE_CYCLES > RETRY_GAP) ? SETTLE_CYCLES : RETRY_GAP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam int RTY_W   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(RETRY_GAP - 1);
    localparam logic [RTY_W-1:0] RTY_LIMIT   = RTY_W'(MAX_RETRIES);
    localparam logic [3:0]       LAST_IDX    = 4'd10;

    // Sequencer states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SEND   = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERROR  = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic [23:0]      data_q, data_d;

    // Register/value words: {reg[6:0], val[8:0]}. Entry 0 is the CODEC soft
    // reset; R9 (active) is written last so the CODEC wakes fully configured.
    function automatic logic [15:0] table_word(input logic [3:0] idx);
        logic [15:0] w;
        case (idx)
            4'd0:    w = 16'h1E00;
            4'd1:    w = 16'h0017;
            4'd2:    w = 16'h0217;
            4'd3:    w = 16'h0479;
            4'd4:    w = 16'h0679;
            4'd5:    w = 16'h0812;
            4'd6:    w = 16'h0A00;
            4'd7:    w = 16'h0C00;
            4'd8:    w = 16'h0E01;
            4'd9:    w = 16'h1000;
            4'd10:   w = 16'h1201;
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    // Next-state logic: handshake, retry policy and delay countdowns
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        data_d  = data_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_SEND;
                    idx_d   = 4'd0;
                    retry_d = '0;
                end
            end

            // Request goes out one cycle after entering SEND, which
            // guarantees at least one low cycle between consecutive writes.
            ST_SEND: begin
                req_d   = 1'b1;
                data_d  = {DEV_ADDR, table_word(idx_q)};
                state_d = ST_WAIT;
            end

            // start is deliberately not looked at here: a completion always
            // takes priority and a restart mid-transfer is not allowed.
            ST_WAIT: begin
                if (i2c_done) begin
                    req_d = 1'b0;
                    if (!i2c_nack) begin
                        if (idx_q == 4'd0) begin
                            state_d = ST_SETTLE;
                            cnt_d   = SETTLE_LOAD;
                        end else if (idx_q == LAST_IDX) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_SEND;
                            idx_d   = idx_q + 4'd1;
                            retry_d = '0;
                        end
                    end else if (retry_q < RTY_LIMIT) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                        retry_d = retry_q + 1'b1;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end

            // Give the CODEC time to come out of its soft reset
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_SEND;
                    idx_d   = 4'd1;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            // Back off before resending the same entry
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_SEND;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset; a reset during a
    // transfer drops the request on the same edge.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            retry_q <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            data_q  <= 24'h000000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            data_q  <= data_d;
        end
    end

    // Status outputs decode directly from the registered state
    assign busy      = (state_q == ST_SEND) || (state_q == ST_WAIT) ||
                       (state_q == ST_SETTLE) || (state_q == ST_GAP);
    assign done      = (state_q == ST_DONE);
    assign error     = (state_q == ST_ERROR);
    assign i2c_req   = req_q;
    assign i2c_data  = data_q;
    assign entry_idx = idx_q;

endmodule

// File: tb/tb_codec_config_sequencer.sv
`timescale 1ns/1ps
// Directed bench for codec_config_sequencer with an I2C engine model that
// completes every request 8 clocks after it rises and NACKs on demand.
module tb_codec_config_sequencer;

    localparam logic [15:0] EXP_TBL [11] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479,
                                             16'h0679, 16'h0812, 16'h0A00, 16'h0C00,
                                             16'h0E01, 16'h1000, 16'h1201};

    logic        clk;
    logic        reset;
    logic        start;
    logic        i2c_req;
    logic [23:0] i2c_data;
    logic        i2c_done;
    logic        i2c_nack;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  entry_idx;

    int n_checks = 0;
    int n_pass   = 0;

    // Engine model / monitor state
    int          cyc = 0;
    logic [23:0] log_data [$];
    int          log_rise [$];
    int          log_fall [$];
    int          nack_entry = -1;
    int          nack_times = 0;
    int          nack_attempts = 0;
    bit          cur_hit = 0;
    bit          req_prev = 0;
    int          age = 0;

    codec_config_sequencer #(
        .DEV_ADDR      (8'h34),
        .SETTLE_CYCLES (20),
        .RETRY_GAP     (5),
        .MAX_RETRIES   (3)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .start     (start),
        .i2c_req   (i2c_req),
        .i2c_data  (i2c_data),
        .i2c_done  (i2c_done),
        .i2c_nack  (i2c_nack),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .entry_idx (entry_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // I2C engine model: logs each request, answers after 8 clocks
    initial begin
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            i2c_done = 1'b0;
            i2c_nack = 1'b0;
            if (i2c_req && !req_prev) begin
                log_data.push_back(i2c_data);
                log_rise.push_back(cyc);
                cur_hit = (nack_entry >= 0) && (nack_entry <= 10) &&
                          (i2c_data == {8'h34, EXP_TBL[nack_entry]});
                if (cur_hit) nack_attempts++;
                $display("req %0d data=%06h cycle=%0d", log_data.size() - 1, i2c_data, cyc);
                age = 0;
            end
            if (!i2c_req && req_prev) log_fall.push_back(cyc);
            if (i2c_req) begin
                if (age == 7) begin
                    i2c_done = 1'b1;
                    i2c_nack = cur_hit && (nack_attempts <= nack_times);
                end
                age++;
            end
            req_prev = i2c_req;
        end
    end

    task automatic start_run();
        @(negedge clk);
        log_data.delete();
        log_rise.delete();
        log_fall.delete();
        nack_attempts = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (done || error) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_log(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (log_data.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (i2c_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", i2c_req); else n_pass++;
        n_checks++; if (i2c_data !== 24'h0) $display("FAIL reset_data got=%06h exp=000000", i2c_data); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
        n_checks++; if (error !== 1'b0) $display("FAIL reset_error got=%b exp=0", error); else n_pass++;
        n_checks++; if (entry_idx !== 4'd0) $display("FAIL reset_idx got=%0d exp=0", entry_idx); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (log_data.size() != 0) $display("FAIL reset_noreq got=%0d exp=0", log_data.size()); else n_pass++;
    endtask

    task automatic test_clean_run();
        bit ok;
        nack_entry = -1;
        start_run();
        n_checks++; if (i2c_req !== 1'b0 || busy !== 1'b1) $display("FAIL clean_send_cycle req=%b busy=%b exp req=0 busy=1", i2c_req, busy); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (i2c_req !== 1'b1) $display("FAIL clean_first_req got=%b exp=1", i2c_req); else n_pass++;
        wait_end(2000, ok);
        n_checks++; if (!ok) $display("FAIL clean_timeout got=0 exp=1"); else n_pass++;
        n_checks++; if (log_data.size() != 11) $display("FAIL clean_count got=%0d exp=11", log_data.size()); else n_pass++;
        for (int i = 0; i < 11 && i < log_data.size(); i++) begin
            n_checks++;
            if (log_data[i] !== {8'h34, EXP_TBL[i]}) $display("FAIL clean_data%0d got=%06h exp=%06h", i, log_data[i], {8'h34, EXP_TBL[i]});
            else n_pass++;
        end
        if (log_rise.size() >= 3 && log_fall.size() >= 2) begin
            n_checks++; if (log_rise[1] - log_fall[0] != 21) $display("FAIL clean_settle_gap got=%0d exp=21", log_rise[1] - log_fall[0]); else n_pass++;
            n_checks++; if (log_rise[2] - log_fall[1] != 1) $display("FAIL clean_next_gap got=%0d exp=1", log_rise[2] - log_fall[1]); else n_pass++;
        end else begin
            n_checks++; $display("FAIL clean_gap_log got=%0d exp=3", log_rise.size());
        end
        n_checks++; if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) $display("FAIL clean_status done=%b busy=%b error=%b exp 1 0 0", done, busy, error); else n_pass++;
        n_checks++; if (entry_idx !== 4'd10) $display("FAIL clean_idx got=%0d exp=10", entry_idx); else n_pass++;
    endtask

    task automatic test_nack_retry();
        bit ok;
        nack_entry = 4;
        nack_times = 2;
        start_run();
        wait_end(2000, ok);
        n_checks++; if (!ok) $display("FAIL retry_timeout got=0 exp=1"); else n_pass++;
        n_checks++; if (log_data.size() != 13) $display("FAIL retry_count got=%0d exp=13", log_data.size()); else n_pass++;
        if (log_data.size() == 13 && log_fall.size() >= 7) begin
            for (int i = 4; i <= 6; i++) begin
                n_checks++;
                if (log_data[i] !== 24'h340679) $display("FAIL retry_data%0d got=%06h exp=340679", i, log_data[i]);
                else n_pass++;
            end
            n_checks++; if (log_data[7] !== 24'h340812) $display("FAIL retry_after got=%06h exp=340812", log_data[7]); else n_pass++;
            n_checks++; if (log_rise[5] - log_fall[4] != 6) $display("FAIL retry_gap1 got=%0d exp=6", log_rise[5] - log_fall[4]); else n_pass++;
            n_checks++; if (log_rise[6] - log_fall[5] != 6) $display("FAIL retry_gap2 got=%0d exp=6", log_rise[6] - log_fall[5]); else n_pass++;
            n_checks++; if (log_data[12] !== 24'h341201) $display("FAIL retry_last got=%06h exp=341201", log_data[12]); else n_pass++;
        end
        n_checks++; if (done !== 1'b1 || error !== 1'b0) $display("FAIL retry_status done=%b error=%b exp 1 0", done, error); else n_pass++;
        nack_entry = -1;
    endtask

    task automatic test_nack_error();
        bit ok;
        nack_entry = 2;
        nack_times = 99;
        start_run();
        wait_end(2000, ok);
        n_checks++; if (!ok) $display("FAIL err_timeout got=0 exp=1"); else n_pass++;
        n_checks++; if (log_data.size() != 6) $display("FAIL err_count got=%0d exp=6", log_data.size()); else n_pass++;
        n_checks++; if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0) $display("FAIL err_status error=%b done=%b busy=%b exp 1 0 0", error, done, busy); else n_pass++;
        n_checks++; if (entry_idx !== 4'd2) $display("FAIL err_idx got=%0d exp=2", entry_idx); else n_pass++;
        repeat (30) @(posedge clk);
        #1;
        n_checks++; if (log_data.size() != 6 || i2c_req !== 1'b0) $display("FAIL err_quiet count=%0d req=%b exp 6 0", log_data.size(), i2c_req); else n_pass++;
        nack_entry = -1;
        start_run();
        n_checks++; if (error !== 1'b0 || busy !== 1'b1) $display("FAIL err_restart error=%b busy=%b exp 0 1", error, busy); else n_pass++;
        wait_end(2000, ok);
        n_checks++; if (!ok || done !== 1'b1) $display("FAIL err_rerun ok=%b done=%b exp 1 1", ok, done); else n_pass++;
        n_checks++; if (log_data.size() != 11 || log_data[0] !== 24'h341E00) $display("FAIL err_rerun_seq count=%0d exp=11", log_data.size()); else n_pass++;
    endtask

    task automatic test_start_during_wait();
        bit ok;
        nack_entry = -1;
        start_run();
        wait_log(6, 1000, ok);
        n_checks++; if (!ok) $display("FAIL sw_reach got=%0d exp=6", log_data.size()); else n_pass++;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n_checks++; if (i2c_req !== 1'b1 || busy !== 1'b1 || entry_idx !== 4'd5) $display("FAIL sw_ignored req=%b busy=%b idx=%0d exp 1 1 5", i2c_req, busy, entry_idx); else n_pass++;
        wait_end(2000, ok);
        n_checks++; if (!ok || done !== 1'b1) $display("FAIL sw_done ok=%b done=%b exp 1 1", ok, done); else n_pass++;
        n_checks++; if (log_data.size() != 11) $display("FAIL sw_count got=%0d exp=11", log_data.size()); else n_pass++;
        if (log_data.size() >= 7) begin
            n_checks++; if (log_data[5] !== 24'h340812 || log_data[6] !== 24'h340A00) $display("FAIL sw_order got=%06h,%06h exp=340812,340A00", log_data[5], log_data[6]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        nack_entry = -1;
        start_run();
        wait_log(8, 1000, ok);
        n_checks++; if (!ok) $display("FAIL rm_reach got=%0d exp=8", log_data.size()); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (i2c_req !== 1'b1 || i2c_data !== 24'h340C00) $display("FAIL rm_active req=%b data=%06h exp 1 340C00", i2c_req, i2c_data); else n_pass++;
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (i2c_req !== 1'b0 || busy !== 1'b0 || entry_idx !== 4'd0) $display("FAIL rm_drop req=%b busy=%b idx=%0d exp 0 0 0", i2c_req, busy, entry_idx); else n_pass++;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        start_run();
        wait_end(2000, ok);
        n_checks++; if (!ok || done !== 1'b1) $display("FAIL rm_done ok=%b done=%b exp 1 1", ok, done); else n_pass++;
        n_checks++; if (log_data.size() != 11 || log_data[0] !== 24'h341E00) $display("FAIL rm_restart count=%0d exp=11 first=341E00", log_data.size()); else n_pass++;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        test_reset();
        test_clean_run();
        test_nack_retry();
        test_nack_error();
        test_start_during_wait();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
